// File: rtl/seq_signed_divider.sv
// seq_signed_divider: restoring signed divider, one quotient bit per enabled cycle.
// Define DIV_ZERO_DETECT_EN for a div_zero flag and Q=all ones, R=A when B=0.
module seq_signed_divider #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] Q,
  output logic [width-1:0] R
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(width);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [width-1:0] r_rem;
  logic [width-1:0] r_quo;
  logic [width-1:0] r_dvsr;
  logic [width-1:0] r_q;
  logic [width-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_sa;
  logic             r_sb;
  logic             r_busy;
  logic             r_done;
`ifdef DIV_ZERO_DETECT_EN
  logic             r_dz;
`endif

  logic [width:0]   w_shift;
  logic             w_ge;
  logic [width-1:0] w_sub;
  logic [width-1:0] w_amag;
  logic [width-1:0] w_bmag;
  logic [width-1:0] w_qfin;
  logic [width-1:0] w_rfin;
  logic             w_last;

  assign w_amag  = A[width-1] ? -A : A;
  assign w_bmag  = B[width-1] ? -B : B;
  assign w_shift = {r_rem, r_quo[width-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvsr};
  assign w_sub   = w_shift[width-1:0] - r_dvsr;
  assign w_last  = r_cnt == CW'(width - 1);

`ifdef DIV_ZERO_DETECT_EN
  assign w_qfin = (r_dvsr == '0) ? '1 :
                  ((r_sa ^ r_sb) ? -r_quo : r_quo);
`else
  assign w_qfin = (r_sa ^ r_sb) ? -r_quo : r_quo;
`endif
  // Remainder follows dividend sign; for B=0 this reproduces A.
  assign w_rfin = r_sa ? -r_rem : r_rem;

  // State register, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  // Next-state logic: capture, width iterations, sign fix-up.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring step, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz   <= 1'b0;
`endif
    end else if (en) begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_rem  <= '0;
            r_quo  <= w_amag;
            r_dvsr <= w_bmag;
            r_sa   <= A[width-1];
            r_sb   <= B[width-1];
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_sub : w_shift[width-1:0];
          r_quo <= {r_quo[width-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        FINISH: begin
          r_q    <= w_qfin;
          r_r    <= w_rfin;
          r_done <= 1'b1;
          r_busy <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
          r_dz   <= r_dvsr == '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Q    = r_q;
  assign R    = r_r;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = r_dz;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: random and directed signed division checks
// against an integer-arithmetic reference model.
module tb_seq_signed_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
`ifdef DIV_ZERO_DETECT_EN
  logic         div_zero;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.width(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_zero (div_zero)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, b,
                       output logic [W-1:0] q, r,
                       output logic dz);
    int sa, sb, qi, ri;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = (sb == 0);
    if (sb == 0) begin
      ri = sa;
`ifdef DIV_ZERO_DETECT_EN
      qi = -1;
`else
      qi = (sa < 0) ? -((1 << W) - 1) : ((1 << W) - 1);
`endif
    end else begin
      qi = sa / sb;
      ri = sa % sb;
    end
    q = qi[W-1:0];
    r = ri[W-1:0];
  endtask

  // Called at the negedge after the capture edge; n = edges until done.
  task automatic wait_done(input int mode, output int n, output int bc);
    n = 0;
    bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      if (mode == 1 && n == 3) en = 1'b0;
      if (mode == 1 && n == 8) en = 1'b1;
      if (mode == 2 && n == 2) begin
        start = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
      end
      if (mode == 2 && n == 4) start = 1'b0;
      if (mode == 3 && n == 8) begin
        start = 1'b1;
        A = 8'd50;
        B = 8'd5;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // mode 0 normal, 1 en stall, 2 restart while busy, 3 back-to-back
  task automatic run(input logic [W-1:0] a, b, input int mode);
    int n, bc;
    logic [W-1:0] eq, er;
    logic edz;
    model(a, b, eq, er, edz);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", busy, 1);
    wait_done(mode, n, bc);
    check("lat", n, (mode == 1) ? W + 6 : W + 1);
    if (mode == 0) check("busy_cyc", bc, W + 1);
    check("q", Q, eq);
    check("r", R, er);
`ifdef DIV_ZERO_DETECT_EN
    check("dz", div_zero, edz);
`endif
    check("busy_end", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("q_hold", Q, eq);
    if (mode == 3) begin
      check("b2b_capt", busy, 1);
      start = 1'b0;
      model(8'd50, 8'd5, eq, er, edz);
      wait_done(0, n, bc);
      check("b2b_lat", n, W + 1);
      check("b2b_q", Q, eq);
      check("b2b_r", R, er);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic seen;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
`ifdef DIV_ZERO_DETECT_EN
    check("rst_dz", div_zero, 0);
`endif
    rst_n = 1'b1;

    run(8'd100, 8'd7, 0);
    run(8'h9C, 8'd7, 0);
    run(8'd100, 8'hF9, 0);
    run(8'h9C, 8'hF9, 0);
    run(8'h80, 8'hFF, 0);
    run(8'd0, 8'd5, 0);
    run(8'h80, 8'd1, 0);
    run(8'hF9, 8'd0, 0);
    run(8'd7, 8'd0, 0);

    run(8'd100, 8'd7, 1);
    run(8'h9C, 8'hF9, 2);
    run(8'd77, 8'hFD, 3);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      case (i % 8)
        0: b = '0;
        1: b = 8'hFF;
        2: a = 8'h80;
        3: b = 8'd1;
        default: ;
      endcase
      run(a, b, (i % 10 == 9) ? 1 : 0);
    end

    @(negedge clk);
    A = 8'd100;
    B = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", Q, 0);
    check("arst_r", R, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("arst_nodone", seen, 0);
    check("arst_idle", busy, 0);
    run(8'd50, 8'd5, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 The block SHALL have one parameter: width, default 8, operand/result bit width (>=2).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, global enable; low freezes all state.
REQ-006 The block SHALL have port start, input, 1, request to begin one division.
REQ-007 The block SHALL have port A, input, width, signed two's-complement dividend.
REQ-008 The block SHALL have port B, input, width, signed two's-complement divisor.
REQ-009 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when Q/R become valid.
REQ-011 The block SHALL have port Q, output, width, signed quotient, registered.
REQ-012 The block SHALL have port R, output, width, signed remainder, registered.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and FINISH. Every transition and register update occurs only on clk edges where en=1.
REQ-014 In IDLE with start=1, the block SHALL capture A and B, form unsigned magnitudes |A| and |B|, store the sign flags, clear the iteration counter, and go to CALC. |-2^(width-1)| = 2^(width-1) unsigned.
REQ-015 CALC SHALL run exactly width restoring iterations, one per enabled edge, MSB first:
- shift the partial remainder left, bringing in the next dividend bit;
- subtract |B| and keep the result if non-negative;
- record the quotient bit.
It then goes to FINISH.
REQ-016 FINISH SHALL apply signs and then return to IDLE:
- Q = -qmag if sign(A) xor sign(B), else qmag;
- R = -rmag if A negative, else rmag;
- the result is truncated toward zero, and R takes the sign of A.
REQ-017 FINISH SHALL register Q and R and assert done=1 on the same edge. done SHALL clear on the next enabled edge.
REQ-018 Latency SHALL be fixed at width+1 enabled edges from the edge sampling start to the edge asserting done, for all operands including B=0.
REQ-019 busy SHALL be 1 from the start-capture edge until the FINISH edge, and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1. A and B SHALL be sampled only at the capture edge.
REQ-021 Back-to-back operation: start=1 at the edge where done rises SHALL NOT be captured, because the FSM is leaving FINISH. start=1 on the following edge (IDLE) SHALL be captured.
REQ-022 Overflow (-2^(width-1) / -1) SHALL yield Q = 2^(width-1) wrapped (0x80 for width 8) and R = 0, with no flag.
REQ-023 Q and R SHALL hold their last values until the next FINISH.
REQ-024 With en=0, all registers, including done, SHALL hold their values.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, regardless of clk, en or the current state:
- state = IDLE;
- busy = 0, done = 0, Q = 0, R = 0;
- internal remainder, quotient, counter and sign registers = 0.
REQ-026 A reset during CALC SHALL abandon the division without asserting done. The first start after reset release SHALL be processed normally.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN SHALL control divide-by-zero handling.
REQ-028 With DIV_ZERO_DETECT_EN defined, the block SHALL have an extra output port div_zero (1 bit, reset 0), and B=0 is handled as follows:
- div_zero is registered at FINISH and held until the next FINISH;
- Q = all ones;
- R = A;
- latency is unchanged.
REQ-029 With DIV_ZERO_DETECT_EN undefined, the div_zero port SHALL be absent, and B=0 yields the raw algorithm result:
- qmag = all ones and rmag = |A|;
- signs are then applied per REQ-016, with sign(B) = 0;
- width 8 example: 7/0 -> Q=0xFF, R=0x07; -7/0 -> Q=0x01, R=0xF9.

Verification
REQ-030 width=8, A=100, B=7, start pulse -> done pulses 9 edges after capture, Q=0x0E, R=0x02, busy high for 9 cycles.
REQ-031 Signed quadrants at width=8:
- -100/7 -> Q=0xF2, R=0xFE;
- 100/-7 -> Q=0xF2, R=0x02;
- -100/-7 -> Q=0x0E, R=0xFE.
REQ-032 Overflow -128/-1 -> Q=0x80, R=0x00. Also 0/5 -> Q=0, R=0, and -128/1 -> Q=0x80, R=0.
REQ-033 Divide by zero, 7/0, checked in both macro builds:
- with DIV_ZERO_DETECT_EN: Q=0xFF, R=0x07, div_zero=1;
- without: Q=0xFF, R=0x07.
REQ-034 Control checks:
- en=0 for 5 cycles mid-CALC -> done is delayed by exactly 5 cycles and the result is unchanged;
- start re-asserted with new operands while busy -> ignored, first result is correct.
REQ-035 rst_n=0 asserted mid-CALC, asynchronously between clk edges -> outputs go to 0 immediately and done never pulses. Next start with 50/5 -> Q=0x0A, R=0.
